// File: rtl/sc_fir_pkg.sv
// Shared constants and types for the stochastic FIR controller slice.
package sc_fir_pkg;

   // Default sample width minus one, tap count and LFSR seed.
   localparam int          N_DEFAULT      = 12;
   localparam int          LENGTH_DEFAULT = 19;
   localparam logic [11:0] SEED_DEFAULT   = 12'hACE;

   // Feedback taps for x^12+x^6+x^4+x+1: register bits 11, 5, 3 and 0.
   localparam logic [11:0] LFSR_TAPS = 12'h829;

   // Controller sequencing: wait for a sample, clear the adder, sweep, present.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR: shifts left, XOR of the tapped bits enters at bit 0.
// Maximal length only for the 12-bit tap constant in the package.
module sc_lfsr
   import sc_fir_pkg::*;
#(
   parameter int           W    = 12,
   parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] seed,
   output logic [W-1:0] value
);

   // Reset and load both restart the sequence from the seed; enable steps it.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments for all registered state so every flop
      // samples pre-edge values regardless of statement order.
      if (reset || load) begin
         value <= seed;
      end else if (enable) begin
         value <= {value[W-2:0], ^(value & TAPS)};
      end
   end

endmodule

// File: rtl/sc_fir_ctrl.sv
// Stochastic FIR controller: owns the delay line, sequences the external
// hardware adder through one full select sweep per sample and captures its count.
module sc_fir_ctrl
   import sc_fir_pkg::*;
#(
   parameter int           N      = N_DEFAULT,
   parameter int           LENGTH = LENGTH_DEFAULT,
   parameter logic [N-1:0] SEED   = SEED_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N:0]   sample_in,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic [N:0]   taps [LENGTH-1:0],
   output logic         hwa_start,
   output logic [N-1:0] R_y,
   output logic [N-1:0] sel_bits,
   input  logic [N:0]   hwa_out,
   input  logic         hwa_done,
   output logic [N:0]   result,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         busy,
   output logic         err
);

   // Last select value of a sweep; the capture happens in that cycle.
   localparam logic [N-1:0] SEL_LAST = '1;

   state_t state;
   logic   accept;
   logic   lfsr_load;
   logic   lfsr_enable;

   assign sample_ready = (state == IDLE) && !reset;
   assign accept       = sample_valid && sample_ready;
   assign busy         = (state != IDLE);
   assign lfsr_load    = (state == LOAD);
   assign lfsr_enable  = (state == RUN);

   // Random threshold source: restarted from SEED in LOAD, stepped in RUN.
   sc_lfsr #(
      .W    (N),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .load   (lfsr_load),
      .enable (lfsr_enable),
      .seed   (SEED),
      .value  (R_y)
   );

   // Delay line: shifts only on an accepted sample, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the delay line is a handful of flops driving the adder directly,
         // so it is cleared on reset; a RAM-style array would be left unreset.
         for (int i = 0; i < LENGTH; i++) begin
            taps[i] <= '0;
         end
      end else if (accept) begin
         taps[0] <= sample_in;
         for (int i = 1; i < LENGTH; i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

   // Sequencer with registered outputs: start pulse, select sweep, capture,
   // result handshake and sticky protocol error.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         hwa_start    <= 1'b0;
         sel_bits     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         hwa_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  hwa_start <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               sel_bits <= '0;
               state    <= RUN;
            end
            RUN: begin
               if (sel_bits == SEL_LAST) begin
                  // The adder must flag done exactly on the final select.
                  if (!hwa_done) err <= 1'b1;
                  result       <= hwa_out;
                  result_valid <= 1'b1;
                  sel_bits     <= '0;
                  state        <= HOLD;
               end else begin
                  if (hwa_done) err <= 1'b1;
                  sel_bits <= sel_bits + N'(1);
               end
            end
            HOLD: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sc_fir_ctrl.sv
// Self-checking bench for sc_fir_ctrl with a behavioural stochastic adder and
// a result scoreboard fed from an independent software model of the sweep.
module tb_sc_fir_ctrl;

   localparam int          N    = 12;
   localparam int          LEN  = 19;
   localparam logic [11:0] SEED = 12'hACE;

   logic        clock = 1'b0;
   logic        reset;
   logic [12:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic [12:0] taps [18:0];
   logic        hwa_start;
   logic [11:0] R_y;
   logic [11:0] sel_bits;
   logic [12:0] hwa_out;
   logic        hwa_done;
   logic [12:0] result;
   logic        result_valid;
   logic        result_ready;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [12:0] exp_q [$];
   logic [12:0] mtaps [LEN];

   always #5 clock = ~clock;

   sc_fir_ctrl #(
      .N      (N),
      .LENGTH (LEN),
      .SEED   (SEED)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .taps         (taps),
      .hwa_start    (hwa_start),
      .R_y          (R_y),
      .sel_bits     (sel_bits),
      .hwa_out      (hwa_out),
      .hwa_done     (hwa_done),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy),
      .err          (err)
   );

   // Behavioural adder: counts cycles where the selected tap beats R_y.
   logic [12:0] ad_cnt;
   logic [11:0] ad_k;
   logic        ad_active;
   logic        ad_hit;
   logic        force_done;

   always_comb begin
      // NOTE: default first so no path leaves ad_hit unassigned (no latch).
      ad_hit = 1'b0;
      if (ad_active) ad_hit = (taps[int'(sel_bits) % LEN][11:0] > R_y);
   end

   assign hwa_out  = ad_cnt + {12'd0, ad_hit};
   assign hwa_done = (ad_active && (ad_k == 12'hFFF)) || force_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         ad_active <= 1'b0;
         ad_cnt    <= '0;
         ad_k      <= '0;
      end else if (hwa_start) begin
         ad_active <= 1'b1;
         ad_cnt    <= '0;
         ad_k      <= '0;
      end else if (ad_active) begin
         ad_cnt <= ad_cnt + {12'd0, ad_hit};
         ad_k   <= ad_k + 12'd1;
         if (ad_k == 12'hFFF) ad_active <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   function automatic logic [11:0] lfsr_next(input logic [11:0] v);
      return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LEN; i++) mtaps[i] = '0;
      exp_q.delete();
   endtask

   task automatic model_push(input logic [12:0] s);
      for (int i = LEN - 1; i > 0; i--) mtaps[i] = mtaps[i-1];
      mtaps[0] = s;
   endtask

   // Expected adder count for a full 4096-cycle sweep over the model delay line.
   function automatic logic [12:0] expect_count();
      logic [11:0] v = SEED;
      int c = 0;
      for (int t = 0; t < 4096; t++) begin
         if (mtaps[t % LEN][11:0] > v) c++;
         v = lfsr_next(v);
      end
      return 13'(c);
   endfunction

   // One complete sample: accept, sweep checks, optional backpressure, result pop.
   task automatic run_sample(input logic [12:0] s, input int hold, output time acc_t);
      logic [11:0] v;
      logic [12:0] held;
      logic [12:0] exp_v;
      bit          seen [4096];
      int k, t, guard;
      int sel_bad, ry_bad, zero_cnt, dup_cnt, hs_bad, bp_bad;
      model_push(s);
      exp_q.push_back(expect_count());
      guard = 0;
      while (!sample_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      check("ready_before_accept", 32'(sample_ready), 32'd1);
      sample_in    = s;
      sample_valid = 1'b1;
      @(posedge clock);
      acc_t = $time;
      @(negedge clock);
      sample_valid = 1'b0;
      check("hwa_start_pulse", 32'(hwa_start), 32'd1);
      check("sel_in_load", 32'(sel_bits), 32'd0);
      check("ready_low_in_load", 32'(sample_ready), 32'd0);
      v = SEED;
      sel_bad = 0; ry_bad = 0; zero_cnt = 0; dup_cnt = 0; hs_bad = 0; bp_bad = 0;
      seen = '{default: 1'b0};
      @(negedge clock);
      k = 2;
      check("busy_in_run", 32'(busy), 32'd1);
      check("ry_first_run", 32'(R_y), 32'(SEED));
      while (!result_valid && k < 4200) begin
         t = k - 2;
         if (hwa_start) hs_bad++;
         if (sel_bits !== 12'(t)) sel_bad++;
         if (R_y !== v) ry_bad++;
         if (R_y == 12'd0) zero_cnt++;
         if (t < 4095) begin
            if (seen[R_y]) dup_cnt++;
            seen[R_y] = 1'b1;
         end
         v = lfsr_next(v);
         @(negedge clock);
         k++;
      end
      check("rv_latency", 32'(k), 32'd4098);
      check("hwa_start_once", 32'(hs_bad), 32'd0);
      check("sel_sweep", 32'(sel_bad), 32'd0);
      check("ry_sequence", 32'(ry_bad), 32'd0);
      check("ry_nonzero", 32'(zero_cnt), 32'd0);
      check("ry_distinct", 32'(dup_cnt), 32'd0);
      if (hold > 0) begin
         result_ready = 1'b0;
         held = result;
         repeat (hold) begin
            @(negedge clock);
            if (!result_valid || result !== held || sample_ready) bp_bad++;
         end
         check("backpressure_hold", 32'(bp_bad), 32'd0);
         result_ready = 1'b1;
      end
      check("rv_at_handshake", 32'(result_valid), 32'd1);
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         check("result", 32'(result), 32'(exp_v));
      end
      @(negedge clock);
      check("rv_drop", 32'(result_valid), 32'd0);
      check("ready_after_result", 32'(sample_ready), 32'd1);
      check("err_clean", 32'(err), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      time acc, prev;
      int  ones, mism, rv_seen;
      // NOTE: bench inputs are driven with blocking assignments at the falling
      // edge, well away from the rising edge the DUT samples on.
      reset        = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      result_ready = 1'b1;
      force_done   = 1'b0;
      model_clear();
      repeat (3) @(negedge clock);
      check("ready_in_reset", 32'(sample_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_ready", 32'(sample_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rv", 32'(result_valid), 32'd0);
      check("rst_ry", 32'(R_y), 32'hACE);
      check("rst_sel", 32'(sel_bits), 32'd0);
      check("rst_start", 32'(hwa_start), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      mism = 0;
      for (int i = 0; i < LEN; i++) if (taps[i] !== 13'd0) mism++;
      check("rst_taps", 32'(mism), 32'd0);

      // Reset at RUN cycle 2000 aborts the sweep.
      @(negedge clock);
      sample_in    = 13'd5;
      sample_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      sample_valid = 1'b0;
      rv_seen = 0;
      repeat (2001) begin
         @(negedge clock);
         if (result_valid) rv_seen++;
      end
      check("sel_at_2000", 32'(sel_bits), 32'd2000);
      reset = 1'b1;
      @(negedge clock);
      if (result_valid) rv_seen++;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_sel", 32'(sel_bits), 32'd0);
      check("abort_ry", 32'(R_y), 32'hACE);
      check("abort_tap0", 32'(taps[0]), 32'd0);
      reset = 1'b0;
      model_clear();
      #1;
      check("abort_ready", 32'(sample_ready), 32'd1);
      repeat (3) begin
         @(negedge clock);
         if (result_valid) rv_seen++;
      end
      check("abort_no_result", 32'(rv_seen), 32'd0);

      // Single sample 0x0800 against the adder model; restarts from the seed.
      run_sample(13'h0800, 0, acc);

      // Early done during RUN sets the sticky error; only reset clears it.
      sample_in    = 13'h0123;
      sample_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      sample_valid = 1'b0;
      repeat (11) @(negedge clock);
      check("err_before", 32'(err), 32'd0);
      force_done = 1'b1;
      @(negedge clock);
      force_done = 1'b0;
      check("err_set", 32'(err), 32'd1);
      repeat (5) @(negedge clock);
      check("err_sticky", 32'(err), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      #1;
      check("err_cleared", 32'(err), 32'd0);

      // Delay line fill with 20 samples, backpressure on the last one.
      prev = 0;
      for (int i = 1; i <= 20; i++) begin
         run_sample(13'(i), (i == 20) ? 100 : 0, acc);
         if (i > 1) check("throughput", 32'((acc - prev) / 10), 32'd4099);
         prev = acc;
      end
      check("tap0", 32'(taps[0]), 32'd20);
      check("tap18", 32'(taps[18]), 32'd2);
      ones = 0;
      mism = 0;
      for (int i = 0; i < LEN; i++) begin
         if (taps[i] == 13'd1) ones++;
         if (taps[i] !== mtaps[i]) mism++;
      end
      check("sample1_discarded", 32'(ones), 32'd0);
      check("taps_vs_model", 32'(mism), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
